// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper: FSM states, 7-segment
// patterns for BCD digits and the blink half-period helper.
package score_keeper_pkg;

  typedef enum logic {PLAY = 1'b0, WON = 1'b1} state_e;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}; entry 0 is the LSB slot.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic int blink_half(input int clk_hz, input int blink_hz);
    int h;
    h = clk_hz / (2 * blink_hz);
    return (h < 1) ? 1 : h;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-7-segment decoder with blanking and selectable polarity.
module seg7_decoder
  import score_keeper_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       active_low,
  output logic [6:0] seg
);

  logic [6:0] raw;

  always_comb begin
    raw = SEG_BLANK;
    if (!blank && digit <= 4'd9) raw = SEG_TABLE[digit];
    seg = active_low ? ~raw : raw;
  end

endmodule

// File: rtl/score_keeper.sv
// N-player BCD score keeper with winner detection and blinking winner display.
// Define SCORE_KEEPER_WIN_BY_TWO_EN to require a two-point lead to win.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int DIGITS         = 2,
  parameter int WIN_SCORE      = 11,
  parameter int CLK_HZ         = 50000000,
  parameter int BLINK_HZ       = 2,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic [NUM_PLAYERS-1:0]          point_i,
  input  logic                            clear_i,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score_o,
  output logic [NUM_PLAYERS*DIGITS*7-1:0] hex_o,
  output logic [NUM_PLAYERS-1:0]          winner_o,
  output logic                            game_over_o
);

  localparam int MAX_SCORE = 10**DIGITS - 1;
  localparam int SW        = $clog2(MAX_SCORE + 1);
  localparam int HALF      = blink_half(CLK_HZ, BLINK_HZ);
  localparam int BW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [SW-1:0] MAX_V = SW'(MAX_SCORE);
  localparam logic [SW-1:0] WIN_V = SW'(WIN_SCORE);
  localparam logic [BW-1:0] TC_V  = BW'(HALF - 1);
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
  localparam logic [SW:0]   TWO_V = (SW+1)'(2);
`endif

  state_e                                state_q, state_d;
  logic [NUM_PLAYERS-1:0][SW-1:0]        bin_q;
  logic [NUM_PLAYERS-1:0][DIGITS*4-1:0]  bcd_q;
  logic [NUM_PLAYERS-1:0]                win_sel, winner_q, winner_d, blank;
  logic [NUM_PLAYERS*DIGITS-1:0][6:0]    seg;
  logic [BW-1:0]                         blink_cnt;
  logic                                  blink_on;
  logic                                  ok;

  function automatic logic [DIGITS*4-1:0] bcd_inc(input logic [DIGITS*4-1:0] v);
    logic [DIGITS*4-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
        else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Binary shadow drives the compares; BCD copy drives outputs. Both step together.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || clear_i) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (state_q == PLAY) begin
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        if (point_i[k] && bin_q[k] != MAX_V) begin
          bin_q[k] <= bin_q[k] + SW'(1);
          bcd_q[k] <= bcd_inc(bcd_q[k]);
        end
      end
    end
  end

  // Descending scan so the lowest qualifying index ends up selected.
  always_comb begin
    win_sel = '0;
    ok      = 1'b0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      ok = (bin_q[k] >= WIN_V);
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (j != k) begin
          if (bin_q[k] == MAX_V) ok = ok & (bin_q[k] > bin_q[j]);
          else                   ok = ok & ({1'b0, bin_q[k]} >= {1'b0, bin_q[j]} + TWO_V);
        end
      end
`endif
      if (ok) win_sel = NUM_PLAYERS'(1) << k;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q  <= PLAY;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    case (state_q)
      PLAY: if (|win_sel) begin
        state_d  = WON;
        winner_d = win_sel;
      end
      WON: ;
    endcase
    if (clear_i) begin
      state_d  = PLAY;
      winner_d = '0;
    end
  end

  // Held at zero/visible outside WON so each win starts with a full visible half-period.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || clear_i || state_q != WON) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == TC_V) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign game_over_o = (state_q == WON);
  assign winner_o    = winner_q;
  assign score_o     = bcd_q;
  assign hex_o       = seg;

  for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_player
    assign blank[k] = game_over_o && winner_q[k] && !blink_on;
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      seg7_decoder u_dec (
        .digit      (bcd_q[k][d*4 +: 4]),
        .blank      (blank[k]),
        .active_low (SEG_ACTIVE_LOW != 0),
        .seg        (seg[k*DIGITS + d])
      );
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: table-driven game sequences, a blink sequence and
// randomized play on two configurations checked against an integer game model.
module tb_score_keeper;

`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
  localparam bit WB2 = 1'b1;
`else
  localparam bit WB2 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pt_a = '0;
  logic        clr_a = 1'b0;
  logic [15:0] score_a;
  logic [27:0] hex_a;
  logic [1:0]  win_a;
  logic        over_a;
  logic [2:0]  pt_b = '0;
  logic        clr_b = 1'b0;
  logic [11:0] score_b;
  logic [20:0] hex_b;
  logic [2:0]  win_b;
  logic        over_b;

  always #5 clk = ~clk;

  score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .CLK_HZ(100),
                 .BLINK_HZ(5), .SEG_ACTIVE_LOW(1)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .point_i(pt_a), .clear_i(clr_a),
    .score_o(score_a), .hex_o(hex_a), .winner_o(win_a), .game_over_o(over_a));

  score_keeper #(.NUM_PLAYERS(3), .DIGITS(1), .WIN_SCORE(9), .CLK_HZ(8),
                 .BLINK_HZ(1), .SEG_ACTIVE_LOW(0)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .point_i(pt_b), .clear_i(clr_b),
    .score_o(score_b), .hex_o(hex_b), .winner_o(win_b), .game_over_o(over_b));

  // Reference model: integer scores per game, cycles spent in the won state.
  int np [2] = '{2, 3};
  int dg [2] = '{2, 1};
  int ws [2] = '{11, 9};
  int hf [2] = '{10, 4};
  int al [2] = '{1, 0};
  int sc [2][4];
  int over [2];
  int wn [2];
  int tw [2];
  logic [6:0] seg_ref [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int n_chk = 0;
  int n_fail = 0;

  function automatic int max_of(input int id);
    return 10**dg[id] - 1;
  endfunction

  function automatic int find_win(input int id);
    for (int k = 0; k < np[id]; k++) begin
      bit good;
      good = (sc[id][k] >= ws[id]);
      if (WB2) begin
        for (int j = 0; j < np[id]; j++) begin
          if (j != k && sc[id][k] - sc[id][j] < ((sc[id][k] == max_of(id)) ? 1 : 2))
            good = 1'b0;
        end
      end
      if (good) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input int id, input int mask, input bit clr, input bit rst);
    int w;
    if (rst || clr) begin
      for (int k = 0; k < 4; k++) sc[id][k] = 0;
      over[id] = 0; wn[id] = 0; tw[id] = 0;
    end else if (over[id] == 0) begin
      w = find_win(id);
      if (w >= 0) begin over[id] = 1; wn[id] = w; tw[id] = 0; end
      for (int k = 0; k < np[id]; k++)
        if (mask[k] && sc[id][k] < max_of(id)) sc[id][k]++;
    end else begin
      tw[id]++;
    end
  endtask

  function automatic logic [63:0] exp_score(input int id);
    logic [63:0] r = '0;
    for (int k = 0; k < np[id]; k++)
      for (int d = 0; d < dg[id]; d++)
        r |= 64'((sc[id][k] / (10**d)) % 10) << ((k*dg[id] + d) * 4);
    return r;
  endfunction

  function automatic logic [63:0] exp_hex(input int id);
    logic [63:0] r = '0;
    logic [6:0]  p;
    for (int k = 0; k < np[id]; k++)
      for (int d = 0; d < dg[id]; d++) begin
        p = seg_ref[(sc[id][k] / (10**d)) % 10];
        if (over[id] != 0 && wn[id] == k && ((tw[id] / hf[id]) % 2) == 1) p = 7'h00;
        if (al[id] != 0) p = ~p;
        r |= 64'(p) << ((k*dg[id] + d) * 7);
      end
    return r;
  endfunction

  function automatic logic [63:0] exp_win(input int id);
    return (over[id] != 0) ? (64'(1) << wn[id]) : 64'(0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  task automatic check_all();
    chk("score_a", 64'(score_a), exp_score(0));
    chk("hex_a",   64'(hex_a),   exp_hex(0));
    chk("win_a",   64'(win_a),   exp_win(0));
    chk("over_a",  64'(over_a),  64'(over[0]));
    chk("score_b", 64'(score_b), exp_score(1));
    chk("hex_b",   64'(hex_b),   exp_hex(1));
    chk("win_b",   64'(win_b),   exp_win(1));
    chk("over_b",  64'(over_b),  64'(over[1]));
  endtask

  task automatic step(input logic [1:0] pa, input logic ca, input logic [2:0] pb, input logic cb);
    pt_a = pa; clr_a = ca; pt_b = pb; clr_b = cb;
    @(posedge clk);
    model_step(0, int'(pa), ca, !rst_n);
    model_step(1, int'(pb), cb, !rst_n);
    #1;
    check_all();
  endtask

  typedef struct {
    logic [1:0]  pt;
    logic        clr;
    int          reps;
    logic [15:0] score;
    logic [1:0]  win;
    logic        over;
  } vec_t;

  vec_t vt [13];

  initial begin
    vt[0]  = '{2'b01, 1'b0, 10, 16'h0010, 2'b00, 1'b0};
    vt[1]  = '{2'b00, 1'b0, 1,  16'h0010, 2'b00, 1'b0};
    vt[2]  = '{2'b00, 1'b1, 1,  16'h0000, 2'b00, 1'b0};
    vt[3]  = '{2'b11, 1'b0, 11, 16'h1111, 2'b00, 1'b0};
    vt[4]  = '{2'b00, 1'b0, 1,  16'h1111, WB2 ? 2'b00 : 2'b01, !WB2};
    vt[5]  = '{2'b11, 1'b0, 3,  WB2 ? 16'h1414 : 16'h1111, WB2 ? 2'b00 : 2'b01, !WB2};
    vt[6]  = '{2'b10, 1'b1, 1,  16'h0000, 2'b00, 1'b0};
    vt[7]  = '{2'b00, 1'b0, 1,  16'h0000, 2'b00, 1'b0};
    vt[8]  = '{2'b11, 1'b0, 10, 16'h1010, 2'b00, 1'b0};
    vt[9]  = '{2'b01, 1'b0, 1,  16'h1011, 2'b00, 1'b0};
    vt[10] = '{2'b00, 1'b0, 1,  16'h1011, WB2 ? 2'b00 : 2'b01, !WB2};
    vt[11] = '{2'b01, 1'b0, 1,  WB2 ? 16'h1012 : 16'h1011, WB2 ? 2'b00 : 2'b01, !WB2};
    vt[12] = '{2'b00, 1'b0, 1,  WB2 ? 16'h1012 : 16'h1011, 2'b01, 1'b1};

    for (int k = 0; k < 2; k++) model_step(k, 0, 1'b0, 1'b1);

    // Reset state
    rst_n = 1'b0;
    step(2'b11, 1'b0, 3'b111, 1'b0);
    step(2'b00, 1'b0, 3'b000, 1'b0);
    chk("rst_score_a", 64'(score_a), 64'(0));
    chk("rst_win_a",   64'(win_a),   64'(0));
    chk("rst_over_a",  64'(over_a),  64'(0));
    chk("rst_hex_a",   64'(hex_a),   64'({4{7'b1000000}}));
    chk("rst_hex_b",   64'(hex_b),   64'({3{7'b0111111}}));
    rst_n = 1'b1;

    // Scripted game sequences on the two-player instance
    for (int i = 0; i < 13; i++) begin
      for (int r = 0; r < vt[i].reps; r++) step(vt[i].pt, vt[i].clr, 3'b000, 1'b0);
      chk("vec_score", 64'(score_a), 64'(vt[i].score));
      chk("vec_win",   64'(win_a),   64'(vt[i].win));
      chk("vec_over",  64'(over_a),  64'(vt[i].over));
      if (i == 0) chk("vec_hex_10", 64'(hex_a[13:0]), 64'({7'b1111001, 7'b1000000}));
    end

    // Blink: 11-0 win, player-0 digits 10 cycles on, 10 off; player 1 steady
    step(2'b00, 1'b1, 3'b000, 1'b0);
    repeat (11) step(2'b01, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(2'b00, 1'b0, 3'b000, 1'b0);
      chk("blink_p0", 64'(hex_a[13:0]),
          ((i / 10) % 2 == 0) ? 64'({7'b1111001, 7'b1111001}) : 64'(14'h3FFF));
      chk("steady_p1", 64'(hex_a[27:14]), 64'({7'b1000000, 7'b1000000}));
    end

    // Reset in the middle of blinking
    rst_n = 1'b0;
    step(2'b11, 1'b0, 3'b000, 1'b0);
    chk("midrst_over", 64'(over_a), 64'(0));
    chk("midrst_hex",  64'(hex_a),  64'({4{7'b1000000}}));
    rst_n = 1'b1;

    // Randomized play on both instances
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom % 600 != 0);
      step(2'($urandom), ($urandom % 50 == 0), 3'($urandom) & 3'($urandom), ($urandom % 40 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
